// File: rtl/seq_detect_ctrl_if.sv
// Word-stream handshake between the host side and the pattern detector front end.
interface seq_detect_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, s_data, input s_ready);
  modport slave  (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// Serializes accepted words MSB-first, matches a programmable overlapping pattern
// on the bit stream, counts hits and raises a sticky threshold interrupt.
module seq_detect_ctrl #(
  parameter int DATA_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic [CNT_W-1:0]   cfg_thresh,
  output logic               cfg_err,
  seq_detect_ctrl_if.slave   s,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               busy,
  output logic               hit,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic               irq,
  input  logic               irq_clr
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);
  localparam logic [3:0] PAT_MAX_L = 4'(PAT_MAX);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]         state;
  logic [DATA_W-1:0]  shreg;
  logic [IW-1:0]      idx;
  logic [PAT_MAX-1:0] pattern;
  logic [PAT_MAX-1:0] hist;
  logic [PAT_MAX-1:0] hist_next;
  logic [PAT_MAX-1:0] mask;
  logic [3:0]         len;
  logic [3:0]         len_clamped;
  logic [3:0]         seen;
  logic [3:0]         seen_next;
  logic [CNT_W-1:0]   thresh;
  logic [CNT_W-1:0]   cnt_next;
  logic               last_bit;
  logic               hs;
  logic               cfg_ok;
  logic               match;
  logic               bump;

  assign last_bit  = (state == SHIFT) && (idx == LAST_IDX);
  // Ready is gated by reset so every output reads 0 while rst is held.
  assign s.s_ready = !rst && ((state == IDLE) || last_bit);
  assign hs        = s.s_valid && s.s_ready;
  assign bit_valid = (state == SHIFT);
  assign busy      = bit_valid;
  assign bit_out   = bit_valid & shreg[DATA_W-1];
  assign cfg_ok    = cfg_we && (state == IDLE) && !hs;

  assign len_clamped = (cfg_len > PAT_MAX_L) ? PAT_MAX_L : cfg_len;
  assign hist_next   = {hist[PAT_MAX-2:0], shreg[DATA_W-1]};
  assign seen_next   = (seen < PAT_MAX_L) ? seen + 4'd1 : seen;

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_MAX; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  assign match    = bit_valid && (len != 4'd0) && (seen_next >= len) &&
                    (((hist_next ^ pattern) & mask) == '0);
  assign bump     = match && (hit_cnt != '1);
  assign cnt_next = hit_cnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      idx   <= '0;
    end else if (state == IDLE) begin
      if (hs) begin
        shreg <= s.s_data;
        idx   <= '0;
        state <= SHIFT;
      end
    end else if (last_bit) begin
      // A word offered on the last bit follows with no bubble.
      idx <= '0;
      if (hs) begin
        shreg <= s.s_data;
      end else begin
        state <= IDLE;
      end
    end else begin
      shreg <= shreg << 1;
      idx   <= idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern <= '0;
      len     <= '0;
      thresh  <= '0;
      hist    <= '0;
      seen    <= '0;
      hit     <= 1'b0;
      hit_cnt <= '0;
      irq     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        pattern <= cfg_pattern;
        len     <= len_clamped;
        thresh  <= cfg_thresh;
        hist    <= '0;
        seen    <= '0;
        hit     <= 1'b0;
        hit_cnt <= '0;
        irq     <= 1'b0;
      end else begin
        hit <= match;
        if (bit_valid) begin
          hist <= hist_next;
          seen <= seen_next;
        end
        if (bump) begin
          hit_cnt <= cnt_next;
        end
        // Setting wins over a coincident clear.
        if (bump && (thresh != '0) && (cnt_next == thresh)) begin
          irq <= 1'b1;
        end else if (irq_clr) begin
          irq <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl; a second instance with a 2-bit counter
// runs the same stimulus to exercise hit_cnt saturation.
module tb_seq_detect_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_we;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic [7:0] cfg_thresh;
  logic       irq_clr;
  logic       s_valid;
  logic [7:0] s_data;

  logic       cfg_err, bit_out, bit_valid, busy, hit, irq;
  logic [7:0] hit_cnt;
  logic       cfg_err2, bit_out2, bit_valid2, busy2, hit2, irq2;
  logic [1:0] hit_cnt2;

  logic [15:0] obs_bits;
  logic [16:0] obs_hits;
  logic [16:0] obs_irqs;
  logic [16:0] obs_errs;

  int checks = 0;
  int errors = 0;

  seq_detect_ctrl_if #(.DATA_W(8)) sif ();
  seq_detect_ctrl_if #(.DATA_W(8)) sif2 ();

  assign sif.s_valid  = s_valid;
  assign sif.s_data   = s_data;
  assign sif2.s_valid = s_valid;
  assign sif2.s_data  = s_data;

  seq_detect_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_thresh(cfg_thresh), .cfg_err(cfg_err), .s(sif.slave),
    .bit_out(bit_out), .bit_valid(bit_valid), .busy(busy), .hit(hit),
    .hit_cnt(hit_cnt), .irq(irq), .irq_clr(irq_clr)
  );

  seq_detect_ctrl #(.DATA_W(8), .PAT_MAX(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_thresh(cfg_thresh[1:0]), .cfg_err(cfg_err2), .s(sif2.slave),
    .bit_out(bit_out2), .bit_valid(bit_valid2), .busy(busy2), .hit(hit2),
    .hit_cnt(hit_cnt2), .irq(irq2), .irq_clr(irq_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len, input logic [7:0] thr);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_thresh  = thr;
    cfg_we      = 1'b1;
    step();
    cfg_we = 1'b0;
    check_output("cfg_accept_err", cfg_err, 0);
  endtask

  // Streams n words; index j of the obs vectors holds what was seen in the cycle after bit j.
  task automatic apply_stimulus(input logic [7:0] w0, input logic [7:0] w1, input int n,
                                input int clr_at, input int cfg_at);
    obs_bits = '0;
    obs_hits = '0;
    obs_irqs = '0;
    obs_errs = '0;
    s_valid  = 1'b1;
    s_data   = w0;
    for (int j = 0; j <= n * 8; j++) begin
      if (j >= 1) begin
        obs_bits[n*8-j] = bit_out;
        obs_hits[j-1]   = hit;
        obs_irqs[j-1]   = irq;
        obs_errs[j-1]   = cfg_err;
      end
      if (j == 1) check_output("bit_valid_first", bit_valid, 1);
      if (j == 3) check_output("ready_mid", sif.s_ready, 0);
      if (j == 8) begin
        check_output("ready_last", sif.s_ready, 1);
        if (n == 2) begin
          s_valid = 1'b1;
          s_data  = w1;
        end
      end
      if (j == clr_at) irq_clr = 1'b1;
      if (j == cfg_at) begin
        cfg_pattern = 8'hFF;
        cfg_len     = 4'd2;
        cfg_thresh  = 8'd1;
        cfg_we      = 1'b1;
      end
      step();
      s_valid = 1'b0;
      irq_clr = 1'b0;
      cfg_we  = 1'b0;
    end
    obs_hits[n*8] = hit;
    obs_irqs[n*8] = irq;
    obs_errs[n*8] = cfg_err;
    check_output("bit_valid_end", bit_valid, 0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_thresh = '0;
    irq_clr = 1'b0; s_valid = 1'b0; s_data = '0;
    step();
    step();
    check_output("rst_ready", sif.s_ready, 0);
    check_output("rst_bit_valid", bit_valid, 0);
    check_output("rst_hit", hit, 0);
    check_output("rst_hit_cnt", hit_cnt, 0);
    check_output("rst_irq", irq, 0);
    check_output("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;
    #1;
    check_output("idle_ready", sif.s_ready, 1);

    // Single 0x55 word against the full 8-bit alternating pattern.
    cfg_write(8'h55, 4'd8, 8'd0);
    apply_stimulus(8'h55, 8'h00, 1, -1, -1);
    check_output("t1_bits", obs_bits, 16'h0055);
    check_output("t1_hits", obs_hits, 17'h00100);
    check_output("t1_cnt", hit_cnt, 1);
    check_output("t1_cnt_sat", hit_cnt2, 1);

    cfg_write(8'h55, 4'd8, 8'd0);
    apply_stimulus(8'h55, 8'h55, 2, -1, -1);
    check_output("t2_bits", obs_bits, 16'h5555);
    check_output("t2_hits", obs_hits, 17'h15500);
    check_output("t2_cnt", hit_cnt, 5);
    check_output("t2_cnt_sat", hit_cnt2, 3);

    cfg_write(8'h55, 4'd8, 8'd3);
    apply_stimulus(8'h55, 8'h55, 2, 13, -1);
    check_output("t3a_irqs", obs_irqs, 17'h01000);
    check_output("t3a_cnt", hit_cnt, 5);
    check_output("t3a_irq", irq, 0);

    // irq_clr on the very edge that sets irq must leave it set.
    cfg_write(8'h55, 4'd8, 8'd3);
    apply_stimulus(8'h55, 8'h55, 2, 12, -1);
    check_output("t3b_irqs", obs_irqs, 17'h1F000);
    check_output("t3b_irq", irq, 1);

    s_valid = 1'b1;
    s_data  = 8'h55;
    step();
    s_valid = 1'b0;
    repeat (4) step();
    check_output("t6_busy_mid", busy, 1);
    rst = 1'b1;
    #1;
    check_output("t6_bit_valid", bit_valid, 0);
    check_output("t6_busy", busy, 0);
    check_output("t6_cnt", hit_cnt, 0);
    check_output("t6_irq", irq, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    apply_stimulus(8'h55, 8'h00, 1, -1, -1);
    check_output("t6_hits", obs_hits, 17'h00000);
    check_output("t6_cnt_after", hit_cnt, 0);

    cfg_write(8'h05, 4'd3, 8'd0);
    apply_stimulus(8'hAD, 8'h00, 1, -1, -1);
    check_output("t4_bits", obs_bits, 16'h00AD);
    check_output("t4_hits", obs_hits, 17'h00128);
    check_output("t4_cnt", hit_cnt, 3);

    cfg_write(8'h55, 4'd8, 8'd0);
    apply_stimulus(8'h55, 8'h00, 1, -1, 4);
    check_output("t5a_errs", obs_errs, 17'h00010);
    check_output("t5a_hits", obs_hits, 17'h00100);
    check_output("t5a_cnt", hit_cnt, 1);

    // History carries over from the previous word, so hits land every other bit.
    apply_stimulus(8'h55, 8'h00, 1, -1, 0);
    check_output("t5b_errs", obs_errs, 17'h00001);
    check_output("t5b_hits", obs_hits, 17'h00154);
    check_output("t5b_cnt", hit_cnt, 5);

    cfg_write(8'h55, 4'd15, 8'd0);
    apply_stimulus(8'h55, 8'h00, 1, -1, -1);
    check_output("t7_clamp_hits", obs_hits, 17'h00100);
    check_output("t7_clamp_cnt", hit_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
